// File: rtl/qpsk_carrier_modulator_pkg.sv
// ----------------------------------------------------------------------------
// qpsk_pkg
//   Shared constants, FSM encoding and the carrier cosine table used by the
//   QPSK carrier modulator and its LUT sub-module.
//   No ports.
// ----------------------------------------------------------------------------
package qpsk_pkg;

    localparam int SYMBOL_CYCLES_DEF = 52;  // must match upstream bit hold time
    localparam int LUT_DEPTH         = 16;
    localparam int LUT_AW            = $clog2(LUT_DEPTH);
    localparam int LUT_AMP_W         = 8;   // table is built for amplitude 127

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // round(127*cos(2*pi*k/16)), k = 0..15
    localparam logic signed [LUT_AMP_W-1:0] COS_TAB [LUT_DEPTH] = '{
        8'sd127,  8'sd117,  8'sd90,   8'sd49,
        8'sd0,   -8'sd49,  -8'sd90,  -8'sd117,
       -8'sd127, -8'sd117, -8'sd90,  -8'sd49,
        8'sd0,    8'sd49,   8'sd90,   8'sd117
    };

    function automatic logic signed [LUT_AMP_W-1:0] cos_lut(input logic [LUT_AW-1:0] k);
        return COS_TAB[k];
    endfunction

endpackage

// File: rtl/qpsk_carrier_modulator_if.sv
// ----------------------------------------------------------------------------
// qpsk_carrier_modulator_if
//   Data/handshake bundle between the bit synchronizer, the carrier modulator
//   and the sample sink.
//   en         : upstream data valid
//   even / odd : I / Q bit from the synchronizer
//   sample     : signed modulated sample (AMP_W+1 bits)
//   sample_vld : sample valid this cycle
//   sym_strobe : one-cycle pulse when a new symbol is latched
//   sym_iq     : latched {I,Q} of the current symbol
//   master = source side (drives bits, observes samples); slave = modulator.
// ----------------------------------------------------------------------------
interface qpsk_carrier_modulator_if #(parameter int AMP_W = 8);

    logic                    en;
    logic                    even;
    logic                    odd;
    logic signed [AMP_W:0]   sample;
    logic                    sample_vld;
    logic                    sym_strobe;
    logic [1:0]              sym_iq;

    modport master (
        output en, even, odd,
        input  sample, sample_vld, sym_strobe, sym_iq
    );

    modport slave (
        input  en, even, odd,
        output sample, sample_vld, sym_strobe, sym_iq
    );

endinterface

// File: rtl/qpsk_carrier_modulator_carrier_lut.sv
// ----------------------------------------------------------------------------
// carrier_lut
//   Dual-read cosine ROM (cos and sin from the same table) with registered
//   outputs. Each output is negated when its data bit is 0 (bit 0 -> -1).
//   clk, rst  : clock, async active-high reset
//   i_idx     : carrier phase index (0..15)
//   i_ibit    : I bit (1 -> +cos, 0 -> -cos)
//   i_qbit    : Q bit (1 -> +sin, 0 -> -sin)
//   o_i_term  : registered signed I*cos term
//   o_q_term  : registered signed Q*sin term
// ----------------------------------------------------------------------------
module carrier_lut
    import qpsk_pkg::*;
#(
    parameter int AMP_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LUT_AW-1:0]       i_idx,
    input  logic                    i_ibit,
    input  logic                    i_qbit,
    output logic signed [AMP_W-1:0] o_i_term,
    output logic signed [AMP_W-1:0] o_q_term
);

    logic [LUT_AW-1:0]       w_sin_idx;
    logic signed [AMP_W-1:0] w_cos;
    logic signed [AMP_W-1:0] w_sin;

    // sin(theta) = cos(theta - pi/2) = cos[k+12], wrap by 4-bit overflow
    assign w_sin_idx = i_idx + LUT_AW'(12);
    assign w_cos     = AMP_W'(cos_lut(i_idx));
    assign w_sin     = AMP_W'(cos_lut(w_sin_idx));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_i_term <= '0;
            o_q_term <= '0;
        end else begin
            o_i_term <= i_ibit ? w_cos : -w_cos;
            o_q_term <= i_qbit ? w_sin : -w_sin;
        end
    end

endmodule

// File: rtl/qpsk_carrier_modulator.sv
// ----------------------------------------------------------------------------
// qpsk_carrier_modulator
//   Produces one signed passband sample per clock, s = I*cos + Q*sin, from the
//   held even (I) / odd (Q) bit streams. Continuous-phase 16-entry carrier,
//   symbol latched every SYMBOL_CYCLES clocks, 2-clock output pipeline.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : qpsk_carrier_modulator_if.slave (en/even/odd in; sample,
//           sample_vld, sym_strobe, sym_iq out)
// ----------------------------------------------------------------------------
module qpsk_carrier_modulator
    import qpsk_pkg::*;
#(
    parameter int SYMBOL_CYCLES = SYMBOL_CYCLES_DEF,
    parameter int AMP_W         = 8,
    parameter int PHASE_STEP    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    qpsk_carrier_modulator_if.slave   bus
);

    localparam int CNT_W = $clog2(SYMBOL_CYCLES);

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_flush_cnt;
    logic [CNT_W-1:0]        r_sym_cnt;
    logic [LUT_AW-1:0]       r_phase;
    logic [1:0]              r_sym_iq;
    logic                    r_strobe;
    logic [2:0]              r_vld_pipe;
    logic signed [AMP_W:0]   r_sample;

    logic                    w_start;
    logic                    w_adv;
    logic                    w_wrap;
    logic                    w_latch;
    logic signed [AMP_W-1:0] w_i_term;
    logic signed [AMP_W-1:0] w_q_term;
    logic signed [AMP_W:0]   w_sum;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.en) w_next_state = RUN;
            RUN:     if (!bus.en) w_next_state = FLUSH;
            FLUSH: begin
                if (bus.en)           w_next_state = RUN;
                else if (r_flush_cnt) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (datapath controls) ----------------
    // Restart from FLUSH behaves exactly like a start from IDLE.
    always_comb begin
        w_start = 1'b0;
        w_adv   = 1'b0;
        w_wrap  = 1'b0;
        case (r_state)
            IDLE, FLUSH: w_start = bus.en;
            RUN: begin
                w_adv  = bus.en;
                w_wrap = bus.en && (r_sym_cnt == CNT_W'(SYMBOL_CYCLES - 1));
            end
            default: ;
        endcase
        w_latch = w_start || w_wrap;
    end

    // ---------------- counters, symbol latch, valid pipe ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flush_cnt <= 1'b0;
            r_sym_cnt   <= '0;
            r_phase     <= '0;
            r_sym_iq    <= '0;
            r_strobe    <= 1'b0;
            r_vld_pipe  <= '0;
        end else begin
            r_flush_cnt <= (r_state == FLUSH) && !bus.en;
            if (w_start) begin
                r_sym_cnt <= '0;
                r_phase   <= '0;
            end else if (w_adv) begin
                r_sym_cnt <= w_wrap ? '0 : r_sym_cnt + CNT_W'(1);
                r_phase   <= r_phase + LUT_AW'(PHASE_STEP);
            end
            // bits are only sampled here, so mid-symbol glitches never reach sym_iq
            if (w_latch) r_sym_iq <= {bus.even, bus.odd};
            r_strobe   <= w_latch;
            // en in IDLE always starts a run, so en alone marks a live index
            r_vld_pipe <= {r_vld_pipe[1:0], bus.en};
        end
    end

    // ---------------- stage 1: signed LUT reads ----------------
    carrier_lut #(.AMP_W(AMP_W)) u_lut (
        .clk      (clk),
        .rst      (reset),
        .i_idx    (r_phase),
        .i_ibit   (r_sym_iq[1]),
        .i_qbit   (r_sym_iq[0]),
        .o_i_term (w_i_term),
        .o_q_term (w_q_term)
    );

    // ---------------- stage 2: add (|sum| <= 254, no overflow) ----------------
    assign w_sum = {w_i_term[AMP_W-1], w_i_term} + {w_q_term[AMP_W-1], w_q_term};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              r_sample <= '0;
        else if (r_vld_pipe[1]) r_sample <= w_sum;
        else                    r_sample <= '0;
    end

    assign bus.sample     = r_sample;
    assign bus.sample_vld = r_vld_pipe[2];
    assign bus.sym_strobe = r_strobe;
    assign bus.sym_iq     = r_sym_iq;

endmodule

// File: tb/tb_qpsk_carrier_modulator.sv
// ----------------------------------------------------------------------------
// tb_qpsk_carrier_modulator
//   Directed bench for qpsk_carrier_modulator. Cycle n is the state just after
//   the n-th rising edge counted from the edge that first sees en=1.
// ----------------------------------------------------------------------------
module tb_qpsk_carrier_modulator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qpsk_carrier_modulator_if #(.AMP_W(8)) bus ();

    qpsk_carrier_modulator #(
        .SYMBOL_CYCLES (52),
        .AMP_W         (8),
        .PHASE_STEP    (1)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // hand-entered round(127*cos(2*pi*k/16))
    int cos_ref [16] = '{127, 117, 90, 49, 0, -49, -90, -117,
                         -127, -117, -90, -49, 0, 49, 90, 117};

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.en   = 1'b0;
        bus.even = 1'b0;
        bus.odd  = 1'b0;
        rst      = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // drive bits + en, take edge 0; returns at cycle 0
    task automatic start(input logic e, input logic o);
        bus.even = e;
        bus.odd  = o;
        bus.en   = 1'b1;
        tick();
    endtask

    task automatic adv(input int n);
        repeat (n) tick();
    endtask

    logic si [3];
    logic sq [3];

    initial begin
        // ---- 1: reset state, then async reset mid-run ----
        do_reset();
        chk("rst_vld",    int'(bus.sample_vld), 0);
        chk("rst_sample", int'(bus.sample),     0);
        chk("rst_strobe", int'(bus.sym_strobe), 0);
        chk("rst_iq",     int'(bus.sym_iq),     0);
        start(1, 1);
        adv(4);                                 // cycle 4: phase 2 -> 90+90
        chk("t1_pre_sample", int'(bus.sample), 180);
        #2;
        bus.en = 1'b0;
        rst    = 1'b1;
        #1;
        chk("t1_async_vld",    int'(bus.sample_vld), 0);
        chk("t1_async_sample", int'(bus.sample),     0);
        chk("t1_async_iq",     int'(bus.sym_iq),     0);
        tick();
        rst = 1'b0;
        tick();
        chk("t1_post_vld",    int'(bus.sample_vld), 0);
        chk("t1_post_strobe", int'(bus.sym_strobe), 0);
        chk("t1_post_iq",     int'(bus.sym_iq),     0);

        // ---- 2: I=1,Q=1 ----
        do_reset();
        start(1, 1);
        chk("t2_strobe0", int'(bus.sym_strobe), 1);
        chk("t2_iq0",     int'(bus.sym_iq),     3);
        chk("t2_vld0",    int'(bus.sample_vld), 0);
        adv(1);
        chk("t2_strobe1", int'(bus.sym_strobe), 0);
        chk("t2_vld1",    int'(bus.sample_vld), 0);
        adv(1);
        chk("t2_vld2",    int'(bus.sample_vld), 1);
        chk("t2_s2",      int'(bus.sample),     127);
        adv(1);
        chk("t2_s3",      int'(bus.sample),     166);
        adv(3);
        chk("t2_s6",      int'(bus.sample),     127);

        // ---- 3: I=0,Q=1 ----
        do_reset();
        start(0, 1);
        chk("t3_iq", int'(bus.sym_iq), 1);
        adv(2);
        chk("t3_s2", int'(bus.sample), -127);
        adv(1);
        chk("t3_s3", int'(bus.sample), -68);

        // ---- 4: glitch ignored, symbol change at 52 ----
        do_reset();
        start(1, 1);
        adv(29);
        bus.even = 1'b0;                        // glitch seen only by edge 30
        tick();
        bus.even = 1'b1;
        adv(2);                                 // cycle 32: phase 14 -> 90-90
        chk("t4_glitch_s32", int'(bus.sample), 0);
        chk("t4_glitch_iq",  int'(bus.sym_iq), 3);
        adv(19);                                // cycle 51
        chk("t4_strobe51", int'(bus.sym_strobe), 0);
        bus.even = 1'b0;
        bus.odd  = 1'b0;
        tick();                                 // cycle 52
        chk("t4_strobe52", int'(bus.sym_strobe), 1);
        chk("t4_iq52",     int'(bus.sym_iq),     0);
        tick();
        chk("t4_s53", int'(bus.sample), 166);
        tick();
        chk("t4_s54", int'(bus.sample), -127);

        // ---- 5: en drop at 20, restart at 40 ----
        do_reset();
        start(1, 0);
        adv(19);
        bus.en = 1'b0;
        tick();                                 // cycle 20
        tick();                                 // cycle 21: phase 19 -> 49-117
        chk("t5_vld21", int'(bus.sample_vld), 1);
        chk("t5_s21",   int'(bus.sample),     -68);
        tick();
        chk("t5_vld22", int'(bus.sample_vld), 0);
        chk("t5_s22",   int'(bus.sample),     0);
        adv(8);                                 // cycle 30
        chk("t5_vld30",    int'(bus.sample_vld), 0);
        chk("t5_strobe30", int'(bus.sym_strobe), 0);
        chk("t5_iq30",     int'(bus.sym_iq),     2);
        adv(9);                                 // cycle 39
        bus.en   = 1'b1;
        bus.even = 1'b0;
        bus.odd  = 1'b1;
        tick();                                 // cycle 40
        chk("t5_strobe40", int'(bus.sym_strobe), 1);
        chk("t5_iq40",     int'(bus.sym_iq),     1);
        tick();
        chk("t5_vld41", int'(bus.sample_vld), 0);
        tick();
        chk("t5_vld42", int'(bus.sample_vld), 1);
        chk("t5_s42",   int'(bus.sample),     -127);

        // ---- 7: en falls exactly on the wrap cycle ----
        do_reset();
        start(1, 1);
        adv(51);
        bus.en   = 1'b0;
        bus.even = 1'b0;
        bus.odd  = 1'b0;
        tick();                                 // cycle 52
        chk("t7_strobe52", int'(bus.sym_strobe), 0);
        chk("t7_iq52",     int'(bus.sym_iq),     3);
        adv(2);
        chk("t7_vld54", int'(bus.sample_vld), 0);

        // ---- 6: three random symbols against the reference model ----
        do_reset();
        for (int s = 0; s < 3; s++) begin
            si[s] = 1'($urandom_range(0, 1));
            sq[s] = 1'($urandom_range(0, 1));
        end
        bus.even = si[0];
        bus.odd  = sq[0];
        bus.en   = 1'b1;
        for (int c = 0; c <= 157; c++) begin
            int n;
            tick();                             // now at cycle c
            chk($sformatf("t6_strobe_c%0d", c), int'(bus.sym_strobe),
                (c < 156 && (c % 52) == 0) ? 1 : 0);
            if (c >= 2) begin
                int p, s, e;
                p = (c - 2) % 16;
                s = (c - 2) / 52;
                e = (si[s] ? 1 : -1) * cos_ref[p] + (sq[s] ? 1 : -1) * cos_ref[(p + 12) % 16];
                chk($sformatf("t6_vld_c%0d", c),    int'(bus.sample_vld), 1);
                chk($sformatf("t6_sample_c%0d", c), int'(bus.sample),     e);
            end
            n = c + 1;
            bus.en = (n < 156);
            if ((n % 52) == 0 && n < 156) begin
                bus.even = si[n / 52];
                bus.odd  = sq[n / 52];
            end else begin
                bus.even = 1'($urandom_range(0, 1));
                bus.odd  = 1'($urandom_range(0, 1));
            end
        end
        tick();
        chk("t6_vld_end", int'(bus.sample_vld), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
